// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg
//   Shared types and constant helpers for the pipelined add/subtract unit.
//   - seg_width()  : bits handled by each pipeline segment
//   - signed_max() : 2^(w-1)-1 as a wide vector (truncate at the use site)
//   - signed_min() : -2^(w-1) as a wide vector (truncate at the use site)
//   - stage_ctrl_t : per-stage control bits carried alongside the data
package pipelined_adder_pkg;

    localparam int PA_MAX_WIDTH = 1024;

    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } stage_ctrl_t;

    function automatic int seg_width(input int w, input int s);
        return w / s;
    endfunction

    function automatic logic [PA_MAX_WIDTH-1:0] signed_max(input int w);
        return (PA_MAX_WIDTH'(1) << (w - 1)) - PA_MAX_WIDTH'(1);
    endfunction

    function automatic logic [PA_MAX_WIDTH-1:0] signed_min(input int w);
        return PA_MAX_WIDTH'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/pipelined_adder_segment.sv
// adder_segment
//   Combinational SEG-bit adder slice; one instance per pipeline stage.
//   Ports:
//     i_a, i_b  SEG-bit operand slices
//     i_cin     carry into the slice
//     o_sum     SEG-bit sum slice
//     o_cout    carry out of the slice MSB
module adder_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit add/subtract unit with the carry chain split into STAGES
//   registered segments. Latency is STAGES cycles, one result per cycle.
//   Optional build macro PIPELINED_ADDER_SATURATE_EN clamps S on signed
//   overflow (cout and ovf still report the raw result).
//   Ports:
//     Clk, Reset          clock, asynchronous active-high reset
//     in_valid/in_ready   operand handshake (A, B, cin, sub)
//     out_valid/out_ready result handshake (S, cout, ovf)
//     sub = 0: A+B+cin ; sub = 1: A-B (cin ignored)
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;

`ifdef PIPELINED_ADDER_SATURATE_EN
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));
`endif

    // Full-width a/b travel with each beat: the upper slices are the skew
    // path for segments not yet added, the finished lower slices of s are
    // the deskew path towards the output.
    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t           r_stage   [STAGES];
    stage_t           w_cur     [STAGES];
    stage_t           w_nxt     [STAGES];
    logic [SEG-1:0]   w_seg_sum [STAGES];
    logic [STAGES-1:0] w_seg_cout;
    logic             w_adv;
    logic             w_ovf;

    assign w_adv = !r_stage[LAST].ctrl.valid || out_ready;

    always_comb begin
        w_cur[0]            = '0;
        w_cur[0].ctrl.valid = in_valid;
        w_cur[0].ctrl.carry = sub | cin;
        w_cur[0].a          = A;
        w_cur[0].b          = sub ? ~B : B;
        for (int k = 1; k < STAGES; k++) begin
            w_cur[k] = r_stage[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_segment #(.SEG(SEG)) u_seg (
            .i_a    (w_cur[k].a[k*SEG +: SEG]),
            .i_b    (w_cur[k].b[k*SEG +: SEG]),
            .i_cin  (w_cur[k].ctrl.carry),
            .o_sum  (w_seg_sum[k]),
            .o_cout (w_seg_cout[k])
        );
    end

    // Operand signs agree but the result sign differs.
    assign w_ovf = (w_cur[LAST].a[MSB] == w_cur[LAST].b[MSB])
                && (w_seg_sum[LAST][SEG-1] != w_cur[LAST].a[MSB]);

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_nxt[k]                 = w_cur[k];
            w_nxt[k].s[k*SEG +: SEG] = w_seg_sum[k];
            w_nxt[k].ctrl.carry      = w_seg_cout[k];
        end
        w_nxt[LAST].ctrl.ovf = w_ovf;
`ifdef PIPELINED_ADDER_SATURATE_EN
        if (w_ovf) begin
            // A negative operand sign means the true result went below min.
            w_nxt[LAST].s = w_cur[LAST].a[MSB] ? SMIN : SMAX;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= w_nxt[k];
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_stage[LAST].ctrl.valid;
    assign S         = r_stage[LAST].s;
    assign cout      = r_stage[LAST].ctrl.carry;
    assign ovf       = r_stage[LAST].ctrl.ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
//   Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
//   Expected results come from a plain-arithmetic reference model or from
//   fixed vectors; a queue holds them in acceptance order.
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass   = 0;
    int   n_checks = 0;
    int   cyc      = 0;
    int   out_cnt;
    int   first_lat;
    bit   got_first;
    int   n_stall;
    bit   use_dir;
    exp_t dir_e;

    logic [15:0] d_a   [4] = '{16'hFF00, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] d_b   [4] = '{16'hFFFF, 16'h0001, 16'h0007, 16'h0001};
    logic        d_cin [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        d_sub [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef PIPELINED_ADDER_SATURATE_EN
    logic [15:0] d_s   [4] = '{16'hFF00, 16'h7FFF, 16'hFFFE, 16'h8000};
`else
    logic [15:0] d_s   [4] = '{16'hFF00, 16'h8000, 16'hFFFE, 16'h7FFF};
`endif
    logic        d_c   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        d_o   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference: true signed sum decides overflow, 17-bit unsigned sum gives cout.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic su);
        exp_t        m;
        logic [15:0] bop;
        int          c0;
        logic [16:0] full;
        int          r;
        bop   = su ? ~b : b;
        c0    = su ? 1 : int'(ci);
        full  = 17'(a) + 17'(bop) + 17'(c0);
        r     = int'($signed(a)) + int'($signed(bop)) + c0;
        m.s   = full[15:0];
        m.c   = full[16];
        m.o   = (r > 32767) || (r < -32768);
        m.acc = 0;
`ifdef PIPELINED_ADDER_SATURATE_EN
        if (m.o) m.s = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        return m;
    endfunction

    task automatic phase_start();
        out_cnt   = 0;
        got_first = 1'b0;
        first_lat = -1;
        n_stall   = 0;
    endtask

    // Called just after a negedge with inputs driven; returns at next negedge.
    task automatic tick(output bit acc);
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && !out_ready) begin
            n_stall++;
            check("stall_in_ready", in_ready, 0);
            if (exp_q.size() > 0) check("stall_S", S, exp_q[0].s);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("S", S, e.s);
                check("cout", cout, e.c);
                check("ovf", ovf, e.o);
                out_cnt++;
                if (!got_first) begin
                    got_first = 1'b1;
                    first_lat = cyc - e.acc;
                end
            end
        end
        if (acc) begin
            e     = use_dir ? dir_e : model(A, B, cin, sub);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        cyc++;
        @(negedge Clk);
    endtask

    task automatic drain();
        bit acc;
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 50) begin
            tick(acc);
            budget++;
        end
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic rand_beat();
        A   = 16'($urandom);
        B   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        bit acc;
        int n;
        int i;
        int first_cyc;
        Reset     = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        use_dir   = 1'b0;
        dir_e     = '{s: 16'h0, c: 1'b0, o: 1'b0, acc: 0};

        @(negedge Clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_S", S, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(negedge Clk);

        // Directed vectors, back-to-back.
        phase_start();
        use_dir = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            A = d_a[k]; B = d_b[k]; cin = d_cin[k]; sub = d_sub[k];
            dir_e = '{s: d_s[k], c: d_c[k], o: d_o[k], acc: 0};
            tick(acc);
        end
        in_valid = 1'b0;
        use_dir  = 1'b0;
        drain();
        check("dir_latency", first_lat, STAGES);
        check("dir_count", out_cnt, 4);

        // Throughput: 8 random beats with no bubbles.
        phase_start();
        first_cyc = cyc;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            rand_beat();
            tick(acc);
        end
        in_valid = 1'b0;
        n = cyc;
        drain();
        check("thru_latency", first_lat, STAGES);
        check("thru_count", out_cnt, 8);
        check("thru_span", cyc - first_cyc, 8 + STAGES);
        check("thru_no_gap", n - first_cyc, 8);

        // Backpressure: 3-cycle out_ready drop mid-stream.
        phase_start();
        n = 0;
        i = 0;
        rand_beat();
        while (n < 6 && i < 40) begin
            out_ready = !(i >= 5 && i < 8);
            in_valid  = 1'b1;
            tick(acc);
            if (acc) begin
                n++;
                rand_beat();
            end
            i++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("bp_accepted", n, 6);
        check("bp_count", out_cnt, 6);
        check("bp_stall_cycles", n_stall, 3);

        // Reset with 3 beats in flight.
        phase_start();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            rand_beat();
            tick(acc);
        end
        in_valid = 1'b0;
        Reset    = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_S", S, 0);
        check("mid_rst_cout", cout, 0);
        exp_q.delete();
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(acc);
            check("post_rst_idle", out_valid, 0);
        end
        phase_start();
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            rand_beat();
            tick(acc);
        end
        in_valid = 1'b0;
        drain();
        check("post_rst_latency", first_lat, STAGES);
        check("post_rst_count", out_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
